// File: rtl/exe_pkg.sv
// Shared types and constants for the execute-stage sequencing controller.
package exe_pkg;

    localparam int REG_W      = 5;
    localparam int CNT_W      = 4;
    localparam int MC_LAT_MIN = 2;
    localparam int MC_LAT_MAX = 16;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MULTI = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/mc_counter.sv
// Down-counter for the iterative unit: load, decrement and zero flag.
module mc_counter
    import exe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Decrement saturates at zero so the count can never wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/exe_seq_ctrl.sv
// Single-in-flight execute controller with writeback handshake and RAW stall.
// Optional build macro EXE_FWD_EN lets a retiring result be forwarded instead of stalling.
module exe_seq_ctrl
    import exe_pkg::*;
#(
    parameter int MC_LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [REG_W-1:0] id_rd,
    input  logic [REG_W-1:0] id_rs_a,
    input  logic [REG_W-1:0] id_rs_b,
    input  logic             id_multicycle,
    input  logic             flush,
    output logic             ex_load,
    output logic             res_load,
    output logic             wb_valid,
    output logic [REG_W-1:0] wb_rd,
    input  logic             wb_ready,
    output logic             busy,
    output logic             fwd_a,
    output logic             fwd_b
);

    localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_LATENCY - 2);

    state_t           state;
    state_t           state_nx;
    logic [REG_W-1:0] infl_rd;
    logic             out_en;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             match_a;
    logic             match_b;
    logic             hazard;
    logic             stall;
    logic             hold_retiring;
    logic             accept;
    logic             retire;

    mc_counter u_mc_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (MC_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign match_a       = (state != IDLE) && (infl_rd != REG_ZERO) && (infl_rd == id_rs_a);
    assign match_b       = (state != IDLE) && (infl_rd != REG_ZERO) && (infl_rd == id_rs_b);
    assign hazard        = match_a || match_b;
    assign hold_retiring = (state == HOLD) && wb_ready;

`ifdef EXE_FWD_EN
    // A hazard against the result retiring this cycle is resolved by forwarding.
    assign stall = hazard && !hold_retiring;
    assign fwd_a = accept && match_a;
    assign fwd_b = accept && match_b;
`else
    assign stall = hazard;
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
`endif

    // out_en keeps id_ready low until the first clock edge after reset release.
    assign id_ready = out_en && ((state == IDLE) || hold_retiring) && !stall && !flush;
    assign accept   = id_valid && id_ready;
    assign ex_load  = accept;
    assign wb_valid = (state == HOLD) && !flush;
    assign retire   = wb_valid && wb_ready;
    assign wb_rd    = infl_rd;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            infl_rd <= REG_ZERO;
            out_en  <= 1'b0;
        end else begin
            state  <= state_nx;
            out_en <= 1'b1;
            if (accept) begin
                infl_rd <= id_rd;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        res_load = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = id_multicycle ? MULTI : HOLD;
                end
            end
            MULTI: begin
                if (flush) begin
                    state_nx = IDLE;
                end else if (cnt_zero) begin
                    res_load = 1'b1;
                    state_nx = HOLD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            HOLD: begin
                if (flush) begin
                    state_nx = IDLE;
                end else if (accept) begin
                    state_nx = id_multicycle ? MULTI : HOLD;
                end else if (retire) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // A new op either captures its result now or starts the iterative count.
        if (accept) begin
            cnt_load = id_multicycle;
            res_load = !id_multicycle;
        end
    end

endmodule

// File: tb/tb_exe_seq_ctrl.sv
// Directed bench for exe_seq_ctrl; expectations follow the build's EXE_FWD_EN setting.
module tb_exe_seq_ctrl;

    localparam int MC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic       id_ready;
    logic [4:0] id_rd = '0;
    logic [4:0] id_rs_a = '0;
    logic [4:0] id_rs_b = '0;
    logic       id_multicycle = 1'b0;
    logic       flush = 1'b0;
    logic       ex_load;
    logic       res_load;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       wb_ready = 1'b0;
    logic       busy;
    logic       fwd_a;
    logic       fwd_b;

    int checks = 0;
    int errors = 0;

    exe_seq_ctrl #(.MC_LATENCY(MC)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_rd         (id_rd),
        .id_rs_a       (id_rs_a),
        .id_rs_b       (id_rs_b),
        .id_multicycle (id_multicycle),
        .flush         (flush),
        .ex_load       (ex_load),
        .res_load      (res_load),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_ready      (wb_ready),
        .busy          (busy),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [4:0] rd, input logic [4:0] rs_a,
                         input logic [4:0] rs_b, input logic multi);
        id_valid      = 1'b1;
        id_rd         = rd;
        id_rs_a       = rs_a;
        id_rs_b       = rs_b;
        id_multicycle = multi;
    endtask

    task automatic no_offer;
        id_valid      = 1'b0;
        id_rd         = '0;
        id_rs_a       = '0;
        id_rs_b       = '0;
        id_multicycle = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: outputs forced low even with an offer present.
        #1 rst = 1'b0;
        offer(5'd3, 5'd0, 5'd0, 1'b0);
        #1;
        chk("rst_id_ready", id_ready, 0);
        chk("rst_ex_load",  ex_load,  0);
        chk("rst_res_load", res_load, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_busy",     busy,     0);
        chk("rst_fwd_a",    fwd_a,    0);
        @(posedge clk);
        #3;
        no_offer();
        rst = 1'b1;
        tick();

        // Single-cycle pass.
        wb_ready = 1'b1;
        offer(5'd3, 5'd1, 5'd2, 1'b0);
        #1;
        chk("sc_id_ready", id_ready, 1);
        chk("sc_ex_load",  ex_load,  1);
        chk("sc_res_load", res_load, 1);
        tick();
        no_offer();
        #1;
        chk("sc_wb_valid", wb_valid, 1);
        chk("sc_wb_rd",    wb_rd,    3);
        chk("sc_busy1",    busy,     1);
        tick();
        #1;
        chk("sc_busy2",     busy,     0);
        chk("sc_wb_valid2", wb_valid, 0);

        // Multicycle latency.
        offer(5'd7, 5'd0, 5'd0, 1'b1);
        #1;
        chk("mc_ex_load",  ex_load,  1);
        chk("mc_res_load0", res_load, 0);
        tick();
        no_offer();
        for (int c = 1; c <= MC; c++) begin
            #1;
            chk("mc_busy",     busy,     1);
            chk("mc_res_load", res_load, (c == MC - 1) ? 8'd1 : 8'd0);
            chk("mc_wb_valid", wb_valid, (c == MC) ? 8'd1 : 8'd0);
            if (c == MC) chk("mc_wb_rd", wb_rd, 7);
            tick();
        end
        #1;
        chk("mc_done_busy", busy, 0);
        tick();

        // RAW hazard against the retiring rd.
        offer(5'd5, 5'd0, 5'd0, 1'b0);
        tick();
        offer(5'd6, 5'd5, 5'd1, 1'b0);
        #1;
        chk("raw_wb_valid", wb_valid, 1);
`ifdef EXE_FWD_EN
        chk("raw_id_ready", id_ready, 1);
        chk("raw_fwd_a",    fwd_a,    1);
        chk("raw_fwd_b",    fwd_b,    0);
        tick();
        no_offer();
        #1;
`else
        chk("raw_id_ready", id_ready, 0);
        chk("raw_fwd_a",    fwd_a,    0);
        tick();
        #1;
        chk("raw_late_ready", id_ready, 1);
        chk("raw_late_load",  ex_load,  1);
        tick();
        no_offer();
        #1;
`endif
        chk("raw_wb_valid2", wb_valid, 1);
        chk("raw_wb_rd2",    wb_rd,    6);
        tick();

        // Register zero never hazards.
        offer(5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        offer(5'd4, 5'd0, 5'd0, 1'b0);
        #1;
        chk("r0_id_ready", id_ready, 1);
        chk("r0_wb_rd",    wb_rd,    0);
        chk("r0_wb_valid", wb_valid, 1);
        tick();
        no_offer();
        #1;
        chk("r0_wb_rd2", wb_rd, 4);
        tick();

        // Flush in MULTI.
        offer(5'd9, 5'd0, 5'd0, 1'b1);
        tick();
        no_offer();
        #1;
        chk("fm_wb_valid1", wb_valid, 0);
        tick();
        flush = 1'b1;
        #1;
        chk("fm_wb_valid2", wb_valid, 0);
        chk("fm_busy2",     busy,     1);
        tick();
        flush = 1'b0;
        offer(5'd2, 5'd0, 5'd0, 1'b0);
        #1;
        chk("fm_busy3",     busy,     0);
        chk("fm_id_ready3", id_ready, 1);
        tick();
        no_offer();
        #1;
        chk("fm_wb_rd4", wb_rd, 2);
        tick();

        // Flush in HOLD gates wb_valid and kills the result.
        wb_ready = 1'b0;
        offer(5'd12, 5'd0, 5'd0, 1'b0);
        tick();
        no_offer();
        flush = 1'b1;
        #1;
        chk("fh_wb_valid", wb_valid, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("fh_busy",      busy,     0);
        chk("fh_wb_valid2", wb_valid, 0);

        // Backpressure, then asynchronous reset mid-HOLD.
        offer(5'd11, 5'd0, 5'd0, 1'b0);
        tick();
        no_offer();
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_wb_valid", wb_valid, 1);
            chk("bp_wb_rd",    wb_rd,    11);
            tick();
        end
        #2;
        rst = 1'b0;
        offer(5'd1, 5'd0, 5'd0, 1'b0);
        #1;
        chk("ar_wb_valid", wb_valid, 0);
        chk("ar_busy",     busy,     0);
        chk("ar_id_ready", id_ready, 0);
        chk("ar_ex_load",  ex_load,  0);
        no_offer();
        wb_ready = 1'b1;
        #1;
        rst = 1'b1;
        tick();
        tick();
        chk("ar_post_wb_valid", wb_valid, 0);
        chk("ar_post_busy",     busy,     0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
